// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package cfg_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_FINISH = 3'd5
    } cfg_state_e;

    // Number of bitstream bytes needed to cover n chain bits.
    function automatic int unsigned byte_count(input int unsigned n);
        return (n + BYTE_W - 32'd1) / BYTE_W;
    endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Phase-length down-counter: reloaded on every phase entry, tc marks the last cycle.
module cfg_phase_timer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);
    localparam int unsigned CW = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 32'd1);

    logic [CW-1:0] cnt_r;

    // Count down to zero and hold there until the next phase reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == '0);

endmodule

// File: rtl/cfg_chain_loader.sv
// Shifts a byte-stream bitstream into the serial configuration chain and
// returns the displaced old chain contents as a readback byte stream.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 3,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out,
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 32'd1);

    cfg_state_e        state_r, state_s;
    logic [BYTE_W-1:0] byte_r, byte_s;
    logic [3:0]        bit_idx_r, bit_idx_s;
    logic [CNT_W-1:0]  total_r, total_s;
    logic [BYTE_W-1:0] rb_sh_r, rb_sh_s, rb_cap_s;
    logic [2:0]        rb_cnt_r, rb_cnt_s;
    logic [BYTE_W-1:0] rb_data_r, rb_data_s;
    logic              rb_valid_r, rb_valid_s;
    logic              prog_in_r, prog_in_s;
    logic              prog_clk_r, prog_clk_s;
    logic              prog_en_r, prog_en_s;
    logic              bs_ready_r, bs_ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              phase_tc_s;

    // Every phase begins with a state change, so that is the reload condition.
    cfg_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_s != state_r),
        .tc    (phase_tc_s)
    );

    // Next-state, datapath counters and readback packing.
    always_comb begin
        state_s    = state_r;
        byte_s     = byte_r;
        bit_idx_s  = bit_idx_r;
        total_s    = total_r;
        rb_sh_s    = rb_sh_r;
        rb_cnt_s   = rb_cnt_r;
        rb_data_s  = rb_data_r;
        rb_valid_s = 1'b0;
        rb_cap_s   = rb_sh_r;
        rb_cap_s[rb_cnt_r] = prog_out;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_FETCH;
                    total_s   = '0;
                    bit_idx_s = 4'd0;
                    rb_sh_s   = '0;
                    rb_cnt_s  = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bs_valid && bs_ready_r) begin
                    byte_s    = bs_data;
                    bit_idx_s = 4'd0;
                    state_s   = ST_SETUP;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_SETUP: begin
                if (phase_tc_s) begin
                    state_s = ST_HIGH;
                    // prog_out still shows the old bit: the chain has not yet clocked.
                    if ((rb_cnt_r == 3'd7) || (total_r == LAST_BIT)) begin
                        rb_data_s  = rb_cap_s;
                        rb_valid_s = 1'b1;
                        rb_sh_s    = '0;
                        rb_cnt_s   = 3'd0;
                    end else begin
                        rb_sh_s  = rb_cap_s;
                        rb_cnt_s = rb_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (phase_tc_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (phase_tc_s) begin
                    total_s   = total_r + CNT_W'(1);
                    bit_idx_s = bit_idx_r + 4'd1;
                    if (total_r == LAST_BIT) begin
                        state_s = ST_FINISH;
                    end else if (bit_idx_r == 4'd7) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_SETUP;
                    end
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output values derived from the upcoming state so the registers line up with it.
    always_comb begin
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_FINISH);
        bs_ready_s = (state_s == ST_FETCH);
        prog_clk_s = (state_s == ST_HIGH);
        prog_en_s  = 1'b0;
        prog_in_s  = 1'b0;
        case (state_s)
            ST_SETUP: begin
                prog_en_s = 1'b1;
                prog_in_s = byte_s[bit_idx_s[2:0]];
            end
            ST_HIGH, ST_LOW: begin
                prog_en_s = 1'b1;
                prog_in_s = prog_in_r;
            end
            ST_FETCH: begin
                // A stall between bytes keeps the chain framed.
                prog_en_s = prog_en_r;
                prog_in_s = prog_in_r;
            end
            default: begin
                prog_en_s = 1'b0;
                prog_in_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            byte_r     <= '0;
            bit_idx_r  <= 4'd0;
            total_r    <= '0;
            rb_sh_r    <= '0;
            rb_cnt_r   <= 3'd0;
            rb_data_r  <= '0;
            rb_valid_r <= 1'b0;
            prog_in_r  <= 1'b0;
            prog_clk_r <= 1'b0;
            prog_en_r  <= 1'b0;
            bs_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_r     <= byte_s;
            bit_idx_r  <= bit_idx_s;
            total_r    <= total_s;
            rb_sh_r    <= rb_sh_s;
            rb_cnt_r   <= rb_cnt_s;
            rb_data_r  <= rb_data_s;
            rb_valid_r <= rb_valid_s;
            prog_in_r  <= prog_in_s;
            prog_clk_r <= prog_clk_s;
            prog_en_r  <= prog_en_s;
            bs_ready_r <= bs_ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bs_ready = bs_ready_r;
    assign prog_in  = prog_in_r;
    assign prog_clk = prog_clk_r;
    assign prog_en  = prog_en_r;
    assign rb_data  = rb_data_r;
    assign rb_valid = rb_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: two instances (3 bits / div 1 and 10 bits / div 2)
// each driving a modelled shift-register chain.
module tb_cfg_chain_loader;

    localparam int L0 = 3;
    localparam int D0 = 1;
    localparam int L1 = 10;
    localparam int D1 = 2;

    logic       clk = 1'b0;
    logic       rst_n    [2];
    logic       start    [2];
    logic [7:0] bs_data  [2];
    logic       bs_valid [2];
    logic       bs_ready [2];
    logic       prog_in  [2];
    logic       prog_clk [2];
    logic       prog_en  [2];
    logic       prog_out [2];
    logic [7:0] rb_data  [2];
    logic       rb_valid [2];
    logic       busy     [2];
    logic       done     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(L0), .CLK_DIV(D0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .bs_data(bs_data[0]),
        .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]), .prog_in(prog_in[0]),
        .prog_clk(prog_clk[0]), .prog_en(prog_en[0]), .prog_out(prog_out[0]),
        .rb_data(rb_data[0]), .rb_valid(rb_valid[0]), .busy(busy[0]), .done(done[0])
    );

    cfg_chain_loader #(.CHAIN_LEN(L1), .CLK_DIV(D1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .bs_data(bs_data[1]),
        .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]), .prog_in(prog_in[1]),
        .prog_clk(prog_clk[1]), .prog_en(prog_en[1]), .prog_out(prog_out[1]),
        .rb_data(rb_data[1]), .rb_valid(rb_valid[1]), .busy(busy[1]), .done(done[1])
    );

    // Fabric chain models: shift on prog_clk rise while enabled, tail drives prog_out.
    logic [15:0] chain0 = 16'h0000;
    logic [15:0] chain1 = 16'h0000;
    int edges0 = 0;
    int edges1 = 0;

    always @(posedge prog_clk[0]) begin
        edges0 <= edges0 + 1;
        if (prog_en[0]) chain0 <= {chain0[14:0], prog_in[0]};
    end
    always @(posedge prog_clk[1]) begin
        edges1 <= edges1 + 1;
        if (prog_en[1]) chain1 <= {chain1[14:0], prog_in[1]};
    end
    assign prog_out[0] = chain0[L0-1];
    assign prog_out[1] = chain1[L1-1];

    // Shared scoreboard state
    int         act = 0;
    logic [7:0] bq[$];
    int         stall_left = 0;
    int         pops = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [6:0] tl_q[$];
    logic [7:0] rb_q[$];
    logic [7:0] rb_log[$];
    bit         cmp_on = 1'b0;
    int         cyc_idx = 0;
    int         done_idx = -1;
    int         done_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, got, got, want, want);
        end
    endtask

    // Byte source: offers the queued bytes, optionally withholding the second one.
    always @(negedge clk) begin
        logic [7:0] dummy;
        if (prev_valid && prev_ready) begin
            dummy = bq.pop_front();
            pops++;
        end
        prev_ready = bs_ready[act];
        if (bq.size() > 0 && pops == 1 && stall_left > 0 && bs_ready[act]) begin
            bs_valid[act] = 1'b0;
            stall_left--;
        end else if (bq.size() > 0) begin
            bs_valid[act] = 1'b1;
            bs_data[act]  = bq[0];
        end else begin
            bs_valid[act] = 1'b0;
        end
        prev_valid = bs_valid[act];
    end

    // Per-cycle comparison against the expected timeline and readback queue.
    logic [6:0] cmp_e;
    logic [5:0] cmp_got;
    logic [5:0] cmp_exp;
    logic [7:0] cmp_rb;
    int         cmp_cur;
    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            cmp_cur = cyc_idx;
            if (tl_q.size() > 0) begin
                cmp_e   = tl_q.pop_front();
                cmp_got = {prog_in[act], busy[act], bs_ready[act], prog_en[act], prog_clk[act], done[act]};
                cmp_exp = cmp_e[5:0];
                if (!cmp_e[6]) cmp_got[5] = cmp_exp[5];
                n_tests++;
                if (cmp_got !== cmp_exp) begin
                    n_fail++;
                    $display("FAIL timeline inst%0d cycle %0d {in,busy,rdy,en,clk,done}: got %b expected %b",
                             act, cmp_cur, cmp_got, cmp_exp);
                end
                cyc_idx++;
            end
            if (done[act]) begin
                done_cnt++;
                done_idx = cmp_cur;
            end
            if (rb_valid[act]) begin
                rb_log.push_back(rb_data[act]);
                n_tests++;
                if (rb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rb_extra inst%0d: got 0x%02h expected no strobe", act, rb_data[act]);
                end else begin
                    cmp_rb = rb_q.pop_front();
                    if (rb_data[act] !== cmp_rb) begin
                        n_fail++;
                        $display("FAIL rb_data inst%0d: got 0x%02h expected 0x%02h", act, rb_data[act], cmp_rb);
                    end
                end
            end
        end
    end

    // One load: builds the expected behaviour from the bitstream and chain model, then runs it.
    task automatic run_load(input int k, input logic [7:0] b0, input logic [7:0] b1,
                            input int stall, input int rst_bit, input int glitch_m);
        int          len, div, nb, bit_no, rst_m, e_start;
        logic [7:0]  bytes [2];
        logic [15:0] ch, expc, mask;
        logic [7:0]  v;
        bit          aborted;
        bytes[0] = b0;
        bytes[1] = b1;
        len  = (k == 1) ? L1 : L0;
        div  = (k == 1) ? D1 : D0;
        nb   = (len + 7) / 8;
        rst_m = (rst_bit >= 0) ? (1 + rst_bit * 3 * div + div + 1) : -1;
        aborted = 1'b0;
        @(negedge clk);
        act = k;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        pops = 0;
        stall_left = stall;
        bq.delete();
        for (int i = 0; i < nb; i++) bq.push_back(bytes[i]);
        // The old chain contents leave tail-first, which is the order they were loaded.
        ch = (k == 1) ? chain1 : chain0;
        rb_q.delete();
        rb_log.delete();
        for (int b = 0; b < nb; b++) begin
            v = 8'h00;
            for (int i = b * 8; i < len && i < b * 8 + 8; i++) v[i % 8] = ch[len - 1 - i];
            rb_q.push_back(v);
        end
        tl_q.delete();
        bit_no = 0;
        for (int kb = 0; kb < nb; kb++) begin
            for (int f = 0; f < 1 + ((kb == 1) ? stall : 0); f++)
                tl_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, (kb > 0), 1'b0, 1'b0});
            for (int j = 0; j < 8; j++) begin
                if (bit_no < len) begin
                    for (int p = 0; p < 3; p++)
                        for (int d = 0; d < div; d++)
                            tl_q.push_back({1'b1, bytes[kb][j], 1'b1, 1'b0, 1'b1, (p == 1), 1'b0});
                    bit_no++;
                end
            end
        end
        tl_q.push_back(7'b1_0_1_0_0_0_1);
        tl_q.push_back(7'b1_0_0_0_0_0_0);
        cyc_idx  = 0;
        done_cnt = 0;
        done_idx = -1;
        e_start  = (k == 1) ? edges1 : edges0;
        start[k] = 1'b1;
        cmp_on   = 1'b1;
        for (int m = 1; m < 600 && tl_q.size() > 0; m++) begin
            @(negedge clk);
            start[k] = (m == glitch_m);
            if (m == rst_m) begin
                chk("rst_pre_prog_clk", int'(prog_clk[k]), 1);
                rst_n[k] = 1'b0;
                #1;
                chk("rst_prog_clk", int'(prog_clk[k]), 0);
                chk("rst_prog_en", int'(prog_en[k]), 0);
                chk("rst_busy", int'(busy[k]), 0);
                cmp_on = 1'b0;
                tl_q.delete();
                rb_q.delete();
                start[k] = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            chk("rst_edges", ((k == 1) ? edges1 : edges0) - e_start, rst_bit + 1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("rst_no_done", int'(done[k]), 0);
            end
            chk("rst_no_done_seen", done_cnt, 0);
            rst_n[k] = 1'b1;
            repeat (2) @(negedge clk);
            bq.delete();
        end else begin
            chk("load_timeout", tl_q.size(), 0);
            repeat (3) @(negedge clk);
            cmp_on = 1'b0;
            chk("rb_missing", rb_q.size(), 0);
            chk("rb_count", rb_log.size(), nb);
            chk("done_count", done_cnt, 1);
            chk("bytes_accepted", pops, nb);
            chk("rising_edges", ((k == 1) ? edges1 : edges0) - e_start, len);
            chk("idle_after", int'(busy[k]), 0);
            ch   = (k == 1) ? chain1 : chain0;
            expc = 16'h0000;
            for (int i = 0; i < len; i++) expc[len - 1 - i] = bytes[i / 8][i % 8];
            mask = (16'd1 << len) - 16'd1;
            chk("chain_contents", int'(ch & mask), int'(expc & mask));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k]    = 1'b0;
            start[k]    = 1'b0;
            bs_valid[k] = 1'b0;
            bs_data[k]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_outputs", int'({prog_in[k], prog_clk[k], prog_en[k], bs_ready[k],
                                       rb_valid[k], busy[k], done[k]}), 0);
            chk("reset_rb_data", int'(rb_data[k]), 0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // 3-bit chain, div 1
        run_load(0, 8'h04, 8'h00, 0, -1, -1);
        chk("t1_rb_literal", int'(rb_log.size() > 0 ? rb_log[0] : 8'hxx), 8'h00);
        chk("t1_done_cycle", done_idx, 10);
        // start on the done cycle (FINISH is timeline entry 10) must be ignored
        run_load(0, 8'h00, 8'h00, 0, -1, 11);
        chk("t2_rb_literal", int'(rb_log.size() > 0 ? rb_log[0] : 8'hxx), 8'h04);

        // 10-bit chain, div 2
        run_load(1, 8'hA5, 8'h03, 0, -1, -1);
        chk("t3_done_cycle", done_idx, 62);
        chk("t3_edges_literal", edges1, 10);
        run_load(1, 8'h00, 8'h00, 0, -1, -1);
        chk("t4_rb0_literal", int'(rb_log.size() > 0 ? rb_log[0] : 8'hxx), 8'hA5);
        chk("t4_rb1_literal", int'(rb_log.size() > 1 ? rb_log[1] : 8'hxx), 8'h03);
        run_load(1, 8'h5A, 8'h02, 7, -1, -1);
        chk("t5_done_cycle", done_idx, 69);
        run_load(1, 8'h3C, 8'h01, 0, 5, -1);
        run_load(1, 8'h96, 8'h01, 0, -1, 3);
        chk("t7_chain_literal", int'(chain1[9:0]), 10'b0110_1001_10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
